// File: rtl/lsu_rv32i_pkg.sv
// Shared definitions for the RV32I load-store unit: funct3 codes, FSM states,
// strobe constants and the access-fault predicate.
package lsu_rv32i_pkg;

  localparam int unsigned STRBW = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [STRBW-1:0] STRB_NONE = 4'b0000;
  localparam logic [STRBW-1:0] STRB_B    = 4'b0001;
  localparam logic [STRBW-1:0] STRB_H    = 4'b0011;
  localparam logic [STRBW-1:0] STRB_W    = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  // Misaligned halfword/word or a funct3 that is not a legal load/store.
  function automatic logic access_fault(input logic       is_store,
                                        input logic [2:0] f3,
                                        input logic [1:0] addr_lo);
    logic f;
    f = 1'b1;
    if (is_store) begin
      case (f3)
        F3_B:    f = 1'b0;
        F3_H:    f = addr_lo[0];
        F3_W:    f = (addr_lo != 2'b00);
        default: f = 1'b1;
      endcase
    end else begin
      case (f3)
        F3_B, F3_BU: f = 1'b0;
        F3_H, F3_HU: f = addr_lo[0];
        F3_W:        f = (addr_lo != 2'b00);
        default:     f = 1'b1;
      endcase
    end
    return f;
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Byte-lane steering: store replication and strobes, load extraction with
// sign/zero extension. Purely combinational.
module lsu_data_align
  import lsu_rv32i_pkg::*;
#(
  parameter int unsigned INT32W = 32
) (
  input  logic [2:0]        st_funct3,
  input  logic [1:0]        st_addr_lo,
  input  logic [INT32W-1:0] st_data,
  output logic [INT32W-1:0] st_wdata_c,
  output logic [STRBW-1:0]  st_wstrb_c,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_addr_lo,
  input  logic [INT32W-1:0] ld_rdata,
  output logic [INT32W-1:0] ld_data_c
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store data is replicated across lanes; the strobe picks the live lane(s).
  always_comb begin
    st_wdata_c = st_data;
    st_wstrb_c = STRB_W;
    case (st_funct3)
      F3_B: begin
        st_wdata_c = {4{st_data[7:0]}};
        st_wstrb_c = STRB_B << st_addr_lo;
      end
      F3_H: begin
        st_wdata_c = {2{st_data[15:0]}};
        st_wstrb_c = STRB_H << {st_addr_lo[1], 1'b0};
      end
      default: begin
        st_wdata_c = st_data;
        st_wstrb_c = STRB_W;
      end
    endcase
  end

  always_comb begin
    ld_byte = ld_rdata[7:0];
    case (ld_addr_lo)
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      2'd3:    ld_byte = ld_rdata[31:24];
      default: ld_byte = ld_rdata[7:0];
    endcase
    ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
  end

  always_comb begin
    ld_data_c = ld_rdata;
    case (ld_funct3)
      F3_B:    ld_data_c = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data_c = {24'h0, ld_byte};
      F3_H:    ld_data_c = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data_c = {16'h0, ld_half};
      default: ld_data_c = ld_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_rv32i.sv
// RV32I memory-stage load-store unit: one transaction at a time over a
// valid/ready memory port, with a one-cycle completion pulse.
module lsu_rv32i
  import lsu_rv32i_pkg::*;
#(
  parameter int unsigned INT32W = 32,
  parameter int unsigned ADDRW  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              isStore,
  input  logic [2:0]        lsFunct3,
  input  logic [ADDRW-1:0]  addrIn,
  input  logic [INT32W-1:0] storeDataIn,
  output logic              memValid,
  input  logic              memReady,
  output logic              memWe,
  output logic [ADDRW-1:0]  memAddr,
  output logic [INT32W-1:0] memWdata,
  output logic [STRBW-1:0]  memWstrb,
  input  logic              memRspValid,
  input  logic [INT32W-1:0] memRdata,
  output logic              doneValid,
  output logic [INT32W-1:0] loadDataOut,
  output logic              misalignOut
);

  lsu_state_e        state;
  logic              cap_store;
  logic [2:0]        cap_funct3;
  logic [1:0]        cap_addr_lo;
  logic              fault_c;
  logic [INT32W-1:0] st_wdata_c;
  logic [STRBW-1:0]  st_wstrb_c;
  logic [INT32W-1:0] ld_data_c;

  assign reqReady = (state == S_IDLE) && !rst;
  assign fault_c  = access_fault(isStore, lsFunct3, addrIn[1:0]);

  // Store path steers the live request; load path uses the captured request.
  lsu_data_align #(
    .INT32W(INT32W)
  ) u_align (
    .st_funct3  (lsFunct3),
    .st_addr_lo (addrIn[1:0]),
    .st_data    (storeDataIn),
    .st_wdata_c (st_wdata_c),
    .st_wstrb_c (st_wstrb_c),
    .ld_funct3  (cap_funct3),
    .ld_addr_lo (cap_addr_lo),
    .ld_rdata   (memRdata),
    .ld_data_c  (ld_data_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cap_store   <= 1'b0;
      cap_funct3  <= 3'b000;
      cap_addr_lo <= 2'b00;
      memValid    <= 1'b0;
      memWe       <= 1'b0;
      memAddr     <= '0;
      memWdata    <= '0;
      memWstrb    <= STRB_NONE;
      doneValid   <= 1'b0;
      misalignOut <= 1'b0;
      loadDataOut <= '0;
    end else begin
      doneValid   <= 1'b0;
      misalignOut <= 1'b0;
      case (state)
        S_IDLE: begin
          if (reqValid) begin
            cap_store   <= isStore;
            cap_funct3  <= lsFunct3;
            cap_addr_lo <= addrIn[1:0];
            if (fault_c) begin
              // Faulting access completes without touching the memory port.
              state       <= S_DONE;
              doneValid   <= 1'b1;
              misalignOut <= 1'b1;
            end else begin
              state    <= S_REQ;
              memValid <= 1'b1;
              memWe    <= isStore;
              memAddr  <= {addrIn[ADDRW-1:2], 2'b00};
              memWdata <= st_wdata_c;
              memWstrb <= isStore ? st_wstrb_c : STRB_NONE;
            end
          end
        end
        S_REQ: begin
          if (memReady) begin
            memValid <= 1'b0;
            memWe    <= 1'b0;
            if (cap_store) begin
              state     <= S_DONE;
              doneValid <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (memRspValid) begin
            loadDataOut <= ld_data_c;
            state       <= S_DONE;
            doneValid   <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_rv32i.sv
// Self-checking bench for lsu_rv32i: table of load/store vectors against a
// small memory responder, scoreboard of completions, plus a reset-in-WAIT case.
module tb_lsu_rv32i;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid;
  logic        reqReady;
  logic        isStore;
  logic [2:0]  lsFunct3;
  logic [31:0] addrIn;
  logic [31:0] storeDataIn;
  logic        memValid;
  logic        memReady;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [3:0]  memWstrb;
  logic        memRspValid;
  logic [31:0] memRdata;
  logic        doneValid;
  logic [31:0] loadDataOut;
  logic        misalignOut;

  always #5 clk = ~clk;

  lsu_rv32i #(
    .INT32W(32),
    .ADDRW (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .reqValid    (reqValid),
    .reqReady    (reqReady),
    .isStore     (isStore),
    .lsFunct3    (lsFunct3),
    .addrIn      (addrIn),
    .storeDataIn (storeDataIn),
    .memValid    (memValid),
    .memReady    (memReady),
    .memWe       (memWe),
    .memAddr     (memAddr),
    .memWdata    (memWdata),
    .memWstrb    (memWstrb),
    .memRspValid (memRspValid),
    .memRdata    (memRdata),
    .doneValid   (doneValid),
    .loadDataOut (loadDataOut),
    .misalignOut (misalignOut)
  );

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          rstall;
    int          pstall;
    logic        fault;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] ld;
  } vec_t;

  typedef struct {
    logic        fault;
    logic [31:0] ld;
    int          lat;
  } exp_t;

  localparam int NVEC = 20;

  vec_t        vecs[NVEC];
  exp_t        sbq[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] last_load;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    exp_t got;
    int   stall;
    int   rcnt;
    logic in_wait;
    logic done;
    @(negedge clk);
    chk($sformatf("v%0d_reqReady", idx), 32'(reqReady), 32'd1);
    reqValid    = 1'b1;
    isStore     = v.st;
    lsFunct3    = v.f3;
    addrIn      = v.addr;
    storeDataIn = v.sdata;
    e.fault = v.fault;
    e.lat   = v.fault ? 1 : (v.st ? 2 + v.rstall : 3 + v.rstall + v.pstall);
    if (!v.fault && !v.st) last_load = v.ld;
    e.ld = last_load;
    sbq.push_back(e);
    stall   = 0;
    rcnt    = 0;
    in_wait = 1'b0;
    done    = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      reqValid    = 1'b0;
      isStore     = 1'b0;
      lsFunct3    = 3'($urandom);
      addrIn      = $urandom;
      storeDataIn = $urandom;
      memReady    = 1'b0;
      memRspValid = 1'b0;
      memRdata    = $urandom;
      if (doneValid) begin
        done = 1'b1;
        if (sbq.size() == 0) begin
          chk($sformatf("v%0d_unexpected_done", idx), 32'd1, 32'd0);
        end else begin
          got = sbq.pop_front();
          chk($sformatf("v%0d_latency", idx), 32'(c), 32'(got.lat));
          chk($sformatf("v%0d_misalign", idx), 32'(misalignOut), 32'(got.fault));
          chk($sformatf("v%0d_loadData", idx), loadDataOut, got.ld);
        end
      end else if (v.fault) begin
        chk($sformatf("v%0d_nomem", idx), 32'(memValid), 32'd0);
      end else if (memValid) begin
        chk($sformatf("v%0d_memAddr", idx), memAddr, v.addr & 32'hFFFF_FFFC);
        chk($sformatf("v%0d_memWe", idx), 32'(memWe), 32'(v.st));
        chk($sformatf("v%0d_memWstrb", idx), 32'(memWstrb), v.st ? 32'(v.wstrb) : 32'd0);
        if (v.st) chk($sformatf("v%0d_memWdata", idx), memWdata, v.wdata);
        if (stall < v.rstall) begin
          stall++;
          // Stray response while the request is still stalled must be ignored.
          if (!v.st) begin
            memRspValid = 1'b1;
            memRdata    = ~v.rdata;
          end
        end else begin
          memReady = 1'b1;
          in_wait  = !v.st;
        end
      end else if (in_wait) begin
        if (rcnt < v.pstall) begin
          rcnt++;
        end else begin
          memRspValid = 1'b1;
          memRdata    = v.rdata;
        end
      end
    end
    memReady    = 1'b0;
    memRspValid = 1'b0;
    if (!done) begin
      chk($sformatf("v%0d_timeout", idx), 32'd1, 32'd0);
      if (sbq.size() != 0) void'(sbq.pop_front());
    end
  endtask

  initial begin
    //          st    f3      addr          sdata         rdata         rs pr fault wdata         wstrb    ld
    vecs[0]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 0, 1'b0, 32'h0,        4'b0000, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_FF00, 0, 0, 1'b0, 32'h0,        4'b0000, 32'hFFFF_FF80};
    vecs[2]  = '{1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_FF00, 0, 0, 1'b0, 32'h0,        4'b0000, 32'h0000_0080};
    vecs[3]  = '{1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0,        3, 0, 1'b0, 32'hABCD_ABCD, 4'b1100, 32'h0};
    vecs[4]  = '{1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        0, 0, 1'b1, 32'h0,        4'b0000, 32'h0};
    vecs[5]  = '{1'b1, 3'b000, 32'h0000_0003, 32'h0000_0055, 32'h0,        0, 0, 1'b0, 32'h5555_5555, 4'b1000, 32'h0};
    vecs[6]  = '{1'b0, 3'b101, 32'h0000_0002, 32'h0,        32'h5500_1234, 0, 0, 1'b0, 32'h0,        4'b0000, 32'h0000_5500};
    vecs[7]  = '{1'b0, 3'b001, 32'h0000_0002, 32'h0,        32'h8000_1234, 0, 2, 1'b0, 32'h0,        4'b0000, 32'hFFFF_8000};
    vecs[8]  = '{1'b0, 3'b001, 32'h0000_0001, 32'h0,        32'h0,        0, 0, 1'b1, 32'h0,        4'b0000, 32'h0};
    vecs[9]  = '{1'b1, 3'b010, 32'h0000_0004, 32'hCAFE_F00D, 32'h0,        1, 0, 1'b0, 32'hCAFE_F00D, 4'b1111, 32'h0};
    vecs[10] = '{1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 1'b1, 32'h0,        4'b0000, 32'h0};
    vecs[11] = '{1'b1, 3'b100, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 1'b1, 32'h0,        4'b0000, 32'h0};
    vecs[12] = '{1'b0, 3'b000, 32'h0000_0001, 32'h0,        32'h0000_7F00, 0, 0, 1'b0, 32'h0,        4'b0000, 32'h0000_007F};
    vecs[13] = '{1'b1, 3'b000, 32'h0000_0001, 32'h0000_00AB, 32'h0,        0, 0, 1'b0, 32'hABAB_ABAB, 4'b0010, 32'h0};
    vecs[14] = '{1'b1, 3'b001, 32'h0000_0000, 32'hFFFF_8001, 32'h0,        0, 0, 1'b0, 32'h8001_8001, 4'b0011, 32'h0};
    vecs[15] = '{1'b0, 3'b001, 32'h0000_0000, 32'h0,        32'h1234_8001, 0, 0, 1'b0, 32'h0,        4'b0000, 32'hFFFF_8001};
    vecs[16] = '{1'b1, 3'b010, 32'h0000_0002, 32'h1111_2222, 32'h0,        0, 0, 1'b1, 32'h0,        4'b0000, 32'h0};
    vecs[17] = '{1'b1, 3'b001, 32'h0000_0003, 32'h1111_2222, 32'h0,        0, 0, 1'b1, 32'h0,        4'b0000, 32'h0};
    vecs[18] = '{1'b0, 3'b010, 32'h0000_0008, 32'h0,        32'h1234_5678, 2, 1, 1'b0, 32'h0,        4'b0000, 32'h1234_5678};
    vecs[19] = '{1'b0, 3'b010, 32'h0000_0044, 32'h0,        32'h0BAD_F00D, 0, 0, 1'b0, 32'h0,        4'b0000, 32'h0BAD_F00D};

    rst         = 1'b1;
    reqValid    = 1'b0;
    isStore     = 1'b0;
    lsFunct3    = 3'b000;
    addrIn      = 32'h0;
    storeDataIn = 32'h0;
    memReady    = 1'b0;
    memRspValid = 1'b0;
    memRdata    = 32'h0;
    last_load   = 32'h0;

    repeat (3) @(negedge clk);
    chk("rst_reqReady", 32'(reqReady), 32'd0);
    chk("rst_memValid", 32'(memValid), 32'd0);
    chk("rst_memWe", 32'(memWe), 32'd0);
    chk("rst_doneValid", 32'(doneValid), 32'd0);
    chk("rst_misalign", 32'(misalignOut), 32'd0);
    chk("rst_memAddr", memAddr, 32'h0);
    chk("rst_memWdata", memWdata, 32'h0);
    chk("rst_memWstrb", 32'(memWstrb), 32'd0);
    chk("rst_loadData", loadDataOut, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < NVEC - 1; i++) run_vec(i, vecs[i]);

    // Reset while a load waits for its response: response is dropped.
    @(negedge clk);
    reqValid = 1'b1;
    isStore  = 1'b0;
    lsFunct3 = 3'b010;
    addrIn   = 32'h0000_0040;
    @(negedge clk);
    reqValid = 1'b0;
    chk("rw_memValid", 32'(memValid), 32'd1);
    memReady = 1'b1;
    @(negedge clk);
    memReady = 1'b0;
    chk("rw_inwait_memValid", 32'(memValid), 32'd0);
    rst = 1'b1;
    #1;
    chk("rw_reqReady_in_rst", 32'(reqReady), 32'd0);
    chk("rw_doneValid_in_rst", 32'(doneValid), 32'd0);
    chk("rw_loadData_in_rst", loadDataOut, 32'h0);
    @(negedge clk);
    rst         = 1'b0;
    memRspValid = 1'b1;
    memRdata    = 32'h1357_2468;
    @(negedge clk);
    memRspValid = 1'b0;
    chk("rw_reqReady_after", 32'(reqReady), 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rw_nodone%0d", k), 32'(doneValid), 32'd0);
      chk($sformatf("rw_loadData%0d", k), loadDataOut, 32'h0);
      @(negedge clk);
    end
    last_load = 32'h0;

    run_vec(NVEC - 1, vecs[NVEC-1]);

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
